// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator and checker.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  // Feedback taps: p = h[10] ^ h[8] ^ h[3] ^ h[1]
  localparam int TAP_A = 10;
  localparam int TAP_B = 8;
  localparam int TAP_C = 3;
  localparam int TAP_D = 1;

  localparam logic [LFSR_W-1:0] TAP_MASK =
    LFSR_W'((1 << TAP_A) | (1 << TAP_B) | (1 << TAP_C) | (1 << TAP_D));

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_state_e;

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR feedback: next bit predicted from the current history.
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic              fb_o
);

  assign fb_o = ^(state_i & TAP_MASK);

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker for the 16-bit Fibonacci LFSR stream: acquires the history,
// verifies a run of correct predictions, then flywheels while counting errors.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_FILL   | loading 16 received bits into the history register
// ST_VERIFY | history loaded, counting consecutive correct predictions
// ST_LOCKED | flywheeling on predictions, counting bits/errors, watching density
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_THRESH = 32,
  parameter int LOSS_WIN    = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        clear_counts,
  output logic        locked,
  output logic [1:0]  state,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [31:0] bit_count
);

  localparam int FILL_W  = $clog2(LFSR_W) + 1;
  localparam int RUN_W   = $clog2(LOCK_THRESH) + 1;
  localparam int WBITS_W = $clog2(LOSS_WIN) + 1;
  localparam int WERRS_W = $clog2(LOSS_THRESH) + 1;

  lfsr_state_e          state_q, state_d;
  logic [LFSR_W-1:0]    h_q, h_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [WBITS_W-1:0]   win_bits_q, win_bits_d;
  logic [WERRS_W-1:0]   win_errs_q, win_errs_d;
  logic [15:0]          err_count_q, err_count_d;
  logic [31:0]          bit_count_q, bit_count_d;
  logic                 err_pulse_q, err_pulse_d;

  logic                 pred;
  logic                 mismatch;
  logic [WERRS_W-1:0]   win_errs_sum;

  lfsr_next u_next (
    .state_i (h_q),
    .fb_o    (pred)
  );

  assign mismatch = in_valid && (in_bit != pred);

  // State and counter registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      h_q         <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  // Next-state: acquisition, verification and locked error-density tracking.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    fill_d       = fill_q;
    run_d        = run_q;
    win_bits_d   = win_bits_q;
    win_errs_d   = win_errs_q;
    err_count_d  = err_count_q;
    bit_count_d  = bit_count_q;
    err_pulse_d  = 1'b0;
    win_errs_sum = win_errs_q + WERRS_W'(mismatch);

    if (in_valid) begin
      unique case (state_q)
        ST_FILL: begin
          h_d = {h_q[LFSR_W-2:0], in_bit};
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            fill_d = '0;
            // An all-zero history is the LFSR lock-up state; keep filling.
            if (h_d != '0) begin
              state_d = ST_VERIFY;
              run_d   = '0;
            end
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end

        ST_VERIFY: begin
          if (mismatch) begin
            state_d = ST_FILL;
            fill_d  = '0;
            run_d   = '0;
          end else begin
            h_d   = {h_q[LFSR_W-2:0], in_bit};
            run_d = run_q + RUN_W'(1);
            if (run_d == RUN_W'(LOCK_THRESH)) begin
              state_d    = ST_LOCKED;
              run_d      = '0;
              win_bits_d = '0;
              win_errs_d = '0;
            end
          end
        end

        ST_LOCKED: begin
          // Flywheel on the prediction so channel errors never reach h.
          h_d         = {h_q[LFSR_W-2:0], pred};
          err_pulse_d = mismatch;
          if (bit_count_q != '1) bit_count_d = bit_count_q + 32'd1;
          if (mismatch && (err_count_q != '1)) err_count_d = err_count_q + 16'd1;

          if (win_errs_sum >= WERRS_W'(LOSS_THRESH)) begin
            state_d    = ST_FILL;
            fill_d     = '0;
            run_d      = '0;
            win_bits_d = '0;
            win_errs_d = '0;
          end else if (win_bits_q == WBITS_W'(LOSS_WIN - 1)) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + WBITS_W'(1);
            win_errs_d = win_errs_sum;
          end
        end

        default: begin
          state_d = ST_FILL;
          fill_d  = '0;
          run_d   = '0;
        end
      endcase
    end

    if (clear_counts) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  assign state     = state_q;
  assign locked    = (state_q == ST_LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker with a bit-history reference model.
module tb_lfsr_checker;

  localparam int LOCK_THRESH = 32;
  localparam int LOSS_WIN    = 64;
  localparam int LOSS_THRESH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear_counts = 1'b0;
  logic        locked;
  logic [1:0]  state;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  lfsr_checker #(
    .LOCK_THRESH (LOCK_THRESH),
    .LOSS_WIN    (LOSS_WIN),
    .LOSS_THRESH (LOSS_THRESH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .clear_counts (clear_counts),
    .locked       (locked),
    .state        (state),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .bit_count    (bit_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Received-bit history kept as a list of bits, newest at the back.
  bit     hist[$];
  int     m_state;    // 0 fill, 1 verify, 2 locked
  int     m_fill, m_run, m_wbits, m_werrs;
  longint m_err, m_bits;
  bit     m_pulse;

  function automatic bit ago(int d);
    return hist[hist.size() - d];
  endfunction

  // The generator recurrence: bit n = bit(n-11) ^ bit(n-9) ^ bit(n-4) ^ bit(n-2).
  function automatic bit model_pred();
    return ago(11) ^ ago(9) ^ ago(4) ^ ago(2);
  endfunction

  function automatic void push(bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endfunction

  function automatic bit hist_zero();
    foreach (hist[i]) if (hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(bit rst, bit v, bit b, bit clr);
    bit p, mm;
    int e;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < 16; i++) hist.push_back(1'b0);
      m_state = 0; m_fill = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
      m_err = 0; m_bits = 0; m_pulse = 0;
      return;
    end
    m_pulse = 0;
    if (v) begin
      p  = model_pred();
      mm = (b != p);
      if (m_state == 0) begin
        push(b);
        m_fill++;
        if (m_fill == 16) begin
          m_fill = 0;
          if (!hist_zero()) begin m_state = 1; m_run = 0; end
        end
      end else if (m_state == 1) begin
        if (mm) begin
          m_state = 0; m_fill = 0; m_run = 0;
        end else begin
          push(b);
          m_run++;
          if (m_run == LOCK_THRESH) begin
            m_state = 2; m_wbits = 0; m_werrs = 0;
          end
        end
      end else begin
        push(p);
        if (m_bits < 64'hFFFF_FFFF) m_bits++;
        if (mm && m_err < 16'hFFFF) m_err++;
        m_pulse = mm;
        e = m_werrs + int'(mm);
        if (e >= LOSS_THRESH) begin
          m_state = 0; m_fill = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
        end else if (m_wbits == LOSS_WIN - 1) begin
          m_wbits = 0; m_werrs = 0;
        end else begin
          m_wbits++; m_werrs = e;
        end
      end
    end
    if (clr) begin m_err = 0; m_bits = 0; end
  endfunction

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("state",     64'(state),     64'(m_state));
      chk("locked",    64'(locked),    64'(m_state == 2));
      chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("bit_count", 64'(bit_count), 64'(m_bits));
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] g_h;

  function automatic bit gen_bit();
    bit p;
    p   = g_h[10] ^ g_h[8] ^ g_h[3] ^ g_h[1];
    g_h = {g_h[14:0], p};
    return p;
  endfunction

  task automatic cyc(input bit rst, input bit v, input bit b, input bit clr);
    @(negedge clk);
    reset = rst; in_valid = v; in_bit = b; clear_counts = clr;
    @(posedge clk);
    model_step(rst, v, b, clr);
    #1;
  endtask

  task automatic send(input bit inv, input bit clr);
    bit b;
    b = gen_bit();
    cyc(1'b0, 1'b1, b ^ inv, clr);
  endtask

  int pulses;
  int bad;

  initial begin
    // Reset, then idle.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'(i), 1'b0);
      if (err_pulse) pulses++;
    end
    chk("idle_state", 64'(state), 64'd0);
    chk("idle_locked", 64'(locked), 64'd0);
    chk("idle_errs", 64'(err_count), 64'd0);
    chk("idle_bits", 64'(bit_count), 64'd0);
    chk("idle_pulses", 64'(pulses), 64'd0);

    // Acquire from seed ACE1: 16 fill + 32 verify.
    g_h = 16'hACE1;
    for (int i = 0; i < 47; i++) send(1'b0, 1'b0);
    chk("pre_lock_locked", 64'(locked), 64'd0);
    chk("pre_lock_state", 64'(state), 64'd1);
    send(1'b0, 1'b0);
    chk("lock48_locked", 64'(locked), 64'd1);
    chk("lock48_state", 64'(state), 64'd2);

    // 1000 clean bits with idle gaps sprinkled in.
    for (int i = 0; i < 1000; i++) begin
      send(1'b0, 1'b0);
      if (i % 50 == 7) cyc(1'b0, 1'b0, 1'(i), 1'b0);
    end
    chk("clean_bits", 64'(bit_count), 64'd1000);
    chk("clean_errs", 64'(err_count), 64'd0);

    // Single error; idle cycle after it must drop the pulse.
    send(1'b1, 1'b0);
    chk("single_pulse", 64'(err_pulse), 64'd1);
    chk("single_errs", 64'(err_count), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_pulse_off", 64'(err_pulse), 64'd0);
    for (int i = 0; i < 100; i++) send(1'b0, 1'b0);
    chk("single_after_errs", 64'(err_count), 64'd1);
    chk("single_after_locked", 64'(locked), 64'd1);

    // 1101 bits since lock; pad to the next window start.
    for (int i = 0; i < 51; i++) send(1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 57; i++) begin
      send(i % 8 == 0, 1'b0);
      if (err_pulse) pulses++;
      if (i == 55) chk("dens_hold7", 64'(locked), 64'd1);
    end
    chk("dens_drop_locked", 64'(locked), 64'd0);
    chk("dens_drop_state", 64'(state), 64'd0);
    chk("dens_pulses", 64'(pulses), 64'd8);
    chk("dens_errs", 64'(err_count), 64'd9);

    // Relock, then 7 errors per window keeps lock.
    for (int i = 0; i < 48; i++) send(1'b0, 1'b0);
    chk("relock_locked", 64'(locked), 64'd1);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 64; i++) send(i < 7, 1'b0);
      chk("win7_locked", 64'(locked), 64'd1);
    end
    chk("win7_errs", 64'(err_count), 64'd37);
    chk("win7_bits", 64'(bit_count), 64'd1465);

    // All-zero stream never leaves FILL.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      if (state != 2'd0) bad++;
    end
    chk("zeros_fill", 64'(bad), 64'd0);

    // Error at run count 20 sends VERIFY back to FILL.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    g_h = 16'hACE1;
    for (int i = 0; i < 36; i++) send(1'b0, 1'b0);
    chk("run20_state", 64'(state), 64'd1);
    send(1'b1, 1'b0);
    chk("run20_err_state", 64'(state), 64'd0);
    for (int i = 0; i < 47; i++) send(1'b0, 1'b0);
    chk("relock47_locked", 64'(locked), 64'd0);
    send(1'b0, 1'b0);
    chk("relock48_locked", 64'(locked), 64'd1);

    // clear_counts wins over a simultaneous error increment.
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    chk("clr_errs", 64'(err_count), 64'd0);
    chk("clr_bits", 64'(bit_count), 64'd0);
    chk("clr_pulse", 64'(err_pulse), 64'd1);
    chk("clr_locked", 64'(locked), 64'd1);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
    chk("clr_after_bits", 64'(bit_count), 64'd5);

    // Reset mid-LOCKED with a valid errored bit.
    begin
      bit b;
      b = gen_bit();
      cyc(1'b1, 1'b1, ~b, 1'b1);
    end
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_pulse", 64'(err_pulse), 64'd0);
    chk("rst_errs", 64'(err_count), 64'd0);
    chk("rst_bits", 64'(bit_count), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 32: consecutive correct bits in VERIFY needed to enter LOCKED.
REQ-002 Parameter LOSS_WIN, default 64: length, in valid bits, of the error-density window used while LOCKED.
REQ-003 Parameter LOSS_THRESH, default 8: errors within one window that cause loss of lock.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_bit is sampled this cycle.
REQ-007 in_bit  input  1  received serial bit; the newest LSB appended by the 16-bit Fibonacci LFSR generator.
REQ-008 clear_counts  input  1  zeroes err_count and bit_count.
REQ-009 locked  output  1  state == LOCKED.
REQ-010 state  output  2  FILL=0, VERIFY=1, LOCKED=2.
REQ-011 err_pulse  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-012 err_count  output  16  saturating count of mismatches while LOCKED.
REQ-013 bit_count  output  32  saturating count of valid bits checked while LOCKED.

Function
REQ-014 History register h[15:0] shall shift left on each valid bit, with the new bit entering h[0].
REQ-015 Predicted bit p shall be h[10]^h[8]^h[3]^h[1]; mismatch means in_valid && (in_bit != p).
REQ-016 Cycles with in_valid=0 shall change no state, counter or output, except that err_pulse clears and clear_counts still applies.
REQ-017 FILL: shift in in_bit and count fill bits 0..15; on the 16th bit, go to VERIFY unless the resulting h == 0, in which case restart FILL with fill count 0.
REQ-018 VERIFY: shift in in_bit; a match increments run count; a mismatch returns to FILL with fill count 0 (the errored bit is discarded).
REQ-019 VERIFY: when run count reaches LOCK_THRESH, go to LOCKED on that same edge.
REQ-020 LOCKED: shift in p, not in_bit (flywheel), so a corrupted bit does not corrupt the prediction.
REQ-021 LOCKED: every valid bit shall increment bit_count; every mismatch shall increment err_count; both saturate (0xFFFF / 0xFFFFFFFF).
REQ-022 LOCKED window rule, per valid bit with e = win_errs + mismatch:
  - if e >= LOSS_THRESH: go to FILL; clear window counters, fill count and run count;
  - else if win_bits == LOSS_WIN-1: win_bits=0, win_errs=0;
  - else: win_bits+1, win_errs=e.
REQ-023 err_pulse shall be registered and high in the cycle after the edge that sampled a LOCKED-state mismatch, including the mismatch that causes loss of lock.
REQ-024 clear_counts zeroes err_count and bit_count on that edge and takes priority over a simultaneous increment; it shall not affect state, h or window counters.
REQ-025 All outputs shall be registered or decoded directly from the state register; latency from sampled bit to output update is one edge.
REQ-026 Bits counted in FILL and VERIFY shall not be added to bit_count or err_count.

Reset
REQ-027 On reset: state=FILL, h=0, fill/run/window counters=0, locked=0, err_pulse=0, err_count=0, bit_count=0.
REQ-028 Reset shall take priority over in_valid and clear_counts, including mid-LOCKED.

Structure
REQ-029 Package lfsr_pkg shall hold LFSR_W=16, the tap constants {10,8,3,1}, and the state enum; the generator and the checker share it.
REQ-030 Sub-module lfsr_next (combinational, 16-bit state in, feedback bit out) shall compute p and be reusable by the generator.
REQ-031 Counters shall be sized as $clog2 of the relevant parameter plus 1.

Verification
REQ-032 Reset, then idle 10 cycles -> state=0, locked=0, counts=0, err_pulse never high.
REQ-033 Generator seeded h=16'hACE1 streams 48 clean valid bits -> locked rises on the edge of bit 48; a further 1000 clean bits -> bit_count=1000, err_count=0.
REQ-034 While locked, invert one bit -> err_pulse high exactly 1 cycle, err_count=1, locked stays 1; following bits match with no further errors.
REQ-035 While locked, invert 8 bits within 64 -> locked drops on the edge of the 8th error, err_pulse fires 8 times; then 7 errors per 64-bit window -> lock held.
REQ-036 Stream 200 zero bits -> state never leaves FILL; inject an error at run count 20 in VERIFY -> state returns to FILL, and relock needs 48 more clean bits.
REQ-037 clear_counts asserted with a mismatch -> err_count=0 next cycle; reset asserted mid-LOCKED with in_valid=1 -> all REQ-027 values next cycle.
